// File: rtl/word_detect_filter_if.sv
// Decision-stream and detection-status bundle for word_detect_filter.
// The master side feeds Viterbi decisions and control; the slave side is the filter.
interface word_detect_filter_if #(
  parameter int CNT_W = 16
);
  logic             result_dv;
  logic             result;
  logic             enable;
  logic             clear;
  logic             detect;
  logic             word_active;
  logic [5:0]       vote;
  logic [CNT_W-1:0] detect_count;

  modport master (
    output result_dv, result, enable, clear,
    input  detect, word_active, vote, detect_count
  );

  modport slave (
    input  result_dv, result, enable, clear,
    output detect, word_active, vote, detect_count
  );
endinterface

// File: rtl/word_detect_filter.sv
// Word-detect post filter: sliding-window majority vote over Viterbi decisions
// with on/off hysteresis, a decision-count holdoff after each word, and a
// saturating detection counter. One detect pulse per word onset.
module word_detect_filter #(
  parameter int WIN     = 8,
  parameter int ON_TH   = 6,
  parameter int OFF_TH  = 2,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  word_detect_filter_if.slave  bus
);

  localparam int FILL_W = $clog2(WIN + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  localparam logic [5:0]        ON_TH_V   = 6'(ON_TH);
  localparam logic [5:0]        OFF_TH_V  = 6'(OFF_TH);
  localparam logic [FILL_W-1:0] WIN_FULL  = FILL_W'(WIN);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_IDLE    = 2'd1,
    S_ACTIVE  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  logic [WIN-1:0]    window;
  logic [5:0]        vote_q;
  logic [FILL_W-1:0] fill;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cnt_q;
  logic              detect_q;
  state_t            state, state_nxt;

  logic              accept;
  logic              oldest;
  logic [5:0]        vote_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              detect_nxt;
  logic              hold_load;
  logic              hold_dec;

  // A decision counts only when enabled and not overridden by a soft clear.
  assign accept   = bus.result_dv & bus.enable & ~bus.clear;
  // Until the window has seen WIN decisions nothing real falls out of it.
  assign oldest   = (fill == WIN_FULL) ? window[WIN-1] : 1'b0;
  assign vote_nxt = vote_q + 6'(bus.result) - 6'(oldest);
  assign fill_nxt = (fill == WIN_FULL) ? fill : fill + FILL_W'(1);

  // Next-state logic: thresholds are judged on the vote including this decision.
  always_comb begin
    state_nxt  = state;
    detect_nxt = 1'b0;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    if (accept) begin
      case (state)
        S_FILL: begin
          // The decision that completes the window is judged as from IDLE.
          if (fill_nxt == WIN_FULL) begin
            if (vote_nxt >= ON_TH_V) begin
              state_nxt  = S_ACTIVE;
              detect_nxt = 1'b1;
            end else begin
              state_nxt  = S_IDLE;
            end
          end
        end
        S_IDLE: begin
          if (vote_nxt >= ON_TH_V) begin
            state_nxt  = S_ACTIVE;
            detect_nxt = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (vote_nxt <= OFF_TH_V) begin
            state_nxt = S_HOLDOFF;
            hold_load = 1'b1;
          end
        end
        S_HOLDOFF: begin
          // Leaving holdoff consumes the decision without a threshold check.
          if (hold_cnt == '0) state_nxt = S_IDLE;
          else                hold_dec  = 1'b1;
        end
        default: state_nxt = S_FILL;
      endcase
    end
  end

  // Window shift register, running vote and fill level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window <= '0;
      vote_q <= '0;
      fill   <= '0;
    end else if (bus.clear) begin
      window <= '0;
      vote_q <= '0;
      fill   <= '0;
    end else if (accept) begin
      window <= {window[WIN-2:0], bus.result};
      vote_q <= vote_nxt;
      fill   <= fill_nxt;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          state <= S_FILL;
    else if (bus.clear) state <= S_FILL;
    else                state <= state_nxt;
  end

  // Holdoff counter, onset pulse and saturating detection counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      detect_q <= 1'b0;
      cnt_q    <= '0;
    end else if (bus.clear) begin
      hold_cnt <= '0;
      detect_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      detect_q <= detect_nxt;
      if (hold_load)     hold_cnt <= HOLD_INIT;
      else if (hold_dec) hold_cnt <= hold_cnt - HOLD_W'(1);
      if (detect_nxt && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.detect       = detect_q;
  assign bus.word_active  = (state == S_ACTIVE);
  assign bus.vote         = vote_q;
  assign bus.detect_count = cnt_q;

endmodule

// File: doc/word_detect_filter.md
Name: word_detect_filter

Overview:
- Post-processing stage directly downstream of the MFCC→HMM→Viterbi word-spotting top level.
- Consumes the per-frame Viterbi decision stream (result_dv/result) and smooths it with a sliding-window majority vote plus on/off hysteresis.
- Emits one clean detect pulse per spoken word and applies a decision-count holdoff before re-arming.
- Feeds LEDs, an interrupt line and a host-readable detection counter.

Parameters:
- WIN, 8: sliding-window length in decisions; legal range 2..32.
- ON_TH, 6: vote at or above which a word starts; constraint OFF_TH < ON_TH <= WIN.
- OFF_TH, 2: vote at or below which a word ends; constraint 0 <= OFF_TH.
- HOLDOFF, 16: decisions ignored after a word ends; legal range >= 1.
- CNT_W, 16: width of the detection counter.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- result_dv, input, 1: decision-valid strobe from Viterbi; may be asserted on consecutive cycles.
- result, input, 1: decision value; 1 = word, 0 = garbage/silence. Sampled only when result_dv=1.
- enable, input, 1: when 0, result_dv is ignored entirely.
- clear, input, 1: synchronous soft clear.
- detect, output, 1: one-cycle pulse at word onset.
- word_active, output, 1: high while state is ACTIVE.
- vote, output, 6: count of ones currently held in the window.
- detect_count, output, CNT_W: number of detections; saturating.

Behaviour:
- Accepted decision: result_dv=1 && enable=1 && clear=0.
- Reset (async) and clear (sync) give identical results:
  - window = 0, vote = 0, fill = 0, holdoff counter = 0;
  - state = FILL;
  - detect = 0, word_active = 0, detect_count = 0.
- clear takes priority over a simultaneous result_dv; that decision is discarded.
- Reset asserted mid-operation forces outputs low immediately, with no clock edge required.
- Window:
  - WIN-bit shift register; each accepted decision shifts result in and the oldest bit out.
  - Update vote incrementally: vote_next = vote + result − oldest.
  - While fill < WIN, treat the oldest bit as 0.
  - fill counts accepted decisions and saturates at WIN.
- All outputs are registered. For an accepted decision at edge t, vote, word_active and detect reflect it at edge t+1 (latency 1).
- State machine: evaluated only on accepted decisions, using vote_next and fill_next.
  - FILL: stay in FILL while fill_next < WIN. When fill_next == WIN, evaluate that same decision as IDLE would.
  - IDLE: if vote_next >= ON_TH, go to ACTIVE, pulse detect for one cycle, and increment detect_count, saturating at 2^CNT_W − 1.
  - ACTIVE: if vote_next <= OFF_TH, go to HOLDOFF and load the holdoff counter with HOLDOFF−1.
  - HOLDOFF:
    - the window keeps updating, but no detect is possible;
    - each accepted decision decrements the counter;
    - an accepted decision arriving with the counter at 0 moves the state to IDLE without evaluating a threshold;
    - the first threshold evaluation happens on the next decision.
- word_active = (state == ACTIVE).
- detect is high for exactly one cycle per onset, even with result_dv asserted on consecutive cycles.
- enable=0 freezes window, vote, fill, state and counters; outputs hold, and detect is 0.

Test Plan:
1. Reset, default parameters, 8 accepted result=1 decisions back-to-back:
   - vote reads 1..8;
   - detect is low for decisions 1–7;
   - detect pulses one cycle after the 8th;
   - word_active=1, detect_count=1.
2. Continuing from 1, feed result=0 decisions:
   - vote reads 7,6,5,4,3,2;
   - on the 6th zero (vote=2), word_active falls and state is HOLDOFF.
   Then feed 16 result=1 decisions:
   - no detect pulse;
   - the 16th returns the state to IDLE.
   The next result=1 (vote=8) gives detect=1 and detect_count=2.
3. enable=0 while 10 result_dv pulses with result=1 arrive:
   - vote, state and detect_count are unchanged;
   - detect stays 0.
   Re-enable and confirm normal accumulation.
4. clear and result_dv=1 in the same cycle, while ACTIVE with vote=8 and count=1:
   - next cycle vote=0, word_active=0, detect_count=0, state FILL.
   - 7 further ones give no detect.
5. Assert reset asynchronously between clock edges while ACTIVE: word_active, vote and detect_count go to 0 before the next edge.
6. With CNT_W=2 and HOLDOFF=1, run 5 full onset/offset cycles: detect pulses 5 times and detect_count saturates at 3.
